// File: rtl/pe_result_writer_pkg.sv
// Shared definitions for the PE result writer: geometry, counter widths,
// FSM state encoding and the ReLU helper used when RESULT_RELU_EN is defined.
package pe_pkg;

    localparam int WORDWIDTH    = 32;
    localparam int NUM1         = 14;
    localparam int NUM2         = 5;
    localparam int CHANNEL      = 6;

    // Partial sums folded into one output point, and output points per row
    localparam int PSUM_PER_OUT = CHANNEL * NUM2;
    localparam int OUT_PER_ROW  = NUM1 - NUM2 + 1;

    localparam int PSUM_CNT_W   = $clog2(PSUM_PER_OUT);
    localparam int OUT_CNT_W    = $clog2(OUT_PER_ROW);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Clamp a signed two's-complement word at zero
    function automatic logic [WORDWIDTH-1:0] relu(input logic [WORDWIDTH-1:0] v);
        logic [WORDWIDTH-1:0] r;
        if (v[WORDWIDTH-1]) begin
            r = '0;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_result_writer_if.sv
// Stream and write-port bundle for the PE result writer.
// slave  : the writer itself (consumes partial sums, issues writes).
// master : the environment (PE array + output buffer side).
interface pe_result_writer_if;
    import pe_pkg::*;

    // partial-sum stream from the PE array
    logic                 in_valid;
    logic [WORDWIDTH-1:0] in_data;
    logic                 in_ready;

    // result write port towards the output SRAM
    logic                 wr_valid;
    logic [OUT_CNT_W-1:0] wr_addr;
    logic [WORDWIDTH-1:0] wr_data;
    logic                 wr_ready;

    modport slave (
        input  in_valid, in_data, wr_ready,
        output in_ready, wr_valid, wr_addr, wr_data
    );

    modport master (
        output in_valid, in_data, wr_ready,
        input  in_ready, wr_valid, wr_addr, wr_data
    );

endinterface

// File: rtl/pe_result_writer_psum_acc.sv
// pe_psum_acc: signed WORDWIDTH-bit accumulator with load/add control.
// Sum wraps modulo 2^WORDWIDTH (no saturation). With RESULT_RELU_EN defined
// the result output is clamped at zero; the stored sum is never modified.
module pe_psum_acc
    import pe_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic                 add_i,
    input  logic [WORDWIDTH-1:0] data_i,
    output logic [WORDWIDTH-1:0] result_o
);

    logic [WORDWIDTH-1:0] acc_q;
    logic [WORDWIDTH-1:0] acc_d;

    // Next accumulator value: load the first partial, add the rest, else hold
    always_comb begin
        acc_d = acc_q;
        if (load_i) begin
            acc_d = data_i;
        end else if (add_i) begin
            acc_d = acc_q + data_i;
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

`ifdef RESULT_RELU_EN
    assign result_o = relu(acc_q);
`else
    assign result_o = acc_q;
`endif

endmodule

// File: rtl/pe_result_writer.sv
// pe_result_writer: consumer end of the PE stream. Accumulates
// PSUM_PER_OUT partial sums per output point and writes OUT_PER_ROW points
// per run, then pulses done. Optional macro RESULT_RELU_EN clamps written
// results at zero (handled inside pe_psum_acc); timing is unchanged.
module pe_result_writer
    import pe_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    pe_result_writer_if.slave  bus,
    output logic               busy,
    output logic               done
);

    localparam logic [PSUM_CNT_W-1:0] PSUM_LAST = PSUM_CNT_W'(PSUM_PER_OUT - 1);
    localparam logic [OUT_CNT_W-1:0]  OUT_LAST  = OUT_CNT_W'(OUT_PER_ROW - 1);

    state_t                state_q;
    state_t                state_d;
    logic [PSUM_CNT_W-1:0] psum_cnt_q;
    logic [PSUM_CNT_W-1:0] psum_cnt_d;
    logic [OUT_CNT_W-1:0]  out_cnt_q;
    logic [OUT_CNT_W-1:0]  out_cnt_d;
    logic                  in_ready_q;
    logic                  in_ready_d;
    logic                  wr_valid_q;
    logic                  wr_valid_d;
    logic                  busy_q;
    logic                  busy_d;
    logic                  done_q;
    logic                  done_d;

    logic                  beat_acc_s;
    logic                  wr_xfer_s;
    logic                  acc_load_s;
    logic                  acc_add_s;
    logic [WORDWIDTH-1:0]  acc_result_s;

    assign beat_acc_s = bus.in_valid & in_ready_q;
    assign wr_xfer_s  = wr_valid_q & bus.wr_ready;

    // Next state, counters and accumulator control; outputs decoded from next state
    always_comb begin
        state_d    = state_q;
        psum_cnt_d = psum_cnt_q;
        out_cnt_d  = out_cnt_q;
        acc_load_s = 1'b0;
        acc_add_s  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ACCUM;
                    psum_cnt_d = '0;
                    out_cnt_d  = '0;
                end else begin
                    state_d    = IDLE;
                end
            end
            ACCUM: begin
                if (beat_acc_s) begin
                    acc_load_s = (psum_cnt_q == '0);
                    acc_add_s  = (psum_cnt_q != '0);
                    if (psum_cnt_q == PSUM_LAST) begin
                        psum_cnt_d = '0;
                        state_d    = WRITE;
                    end else begin
                        psum_cnt_d = psum_cnt_q + PSUM_CNT_W'(1);
                    end
                end else begin
                    state_d = ACCUM;
                end
            end
            WRITE: begin
                if (wr_xfer_s) begin
                    if (out_cnt_q == OUT_LAST) begin
                        out_cnt_d = '0;
                        state_d   = DONE;
                    end else begin
                        out_cnt_d = out_cnt_q + OUT_CNT_W'(1);
                        state_d   = ACCUM;
                    end
                end else begin
                    state_d = WRITE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d    = IDLE;
                psum_cnt_d = '0;
                out_cnt_d  = '0;
            end
        endcase

        in_ready_d = (state_d == ACCUM);
        wr_valid_d = (state_d == WRITE);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    // State, counters and registered handshake/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            psum_cnt_q <= '0;
            out_cnt_q  <= '0;
            in_ready_q <= 1'b0;
            wr_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            psum_cnt_q <= psum_cnt_d;
            out_cnt_q  <= out_cnt_d;
            in_ready_q <= in_ready_d;
            wr_valid_q <= wr_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    pe_psum_acc u_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (acc_load_s),
        .add_i    (acc_add_s),
        .data_i   (bus.in_data),
        .result_o (acc_result_s)
    );

    assign bus.in_ready = in_ready_q;
    assign bus.wr_valid = wr_valid_q;
    assign bus.wr_addr  = out_cnt_q;
    assign bus.wr_data  = acc_result_s;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_pe_result_writer.sv
// Directed testbench for pe_result_writer with a write scoreboard.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_pe_result_writer;
    import pe_pkg::*;

    logic clk;
    logic rst_n;
    logic start;
    logic busy;
    logic done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [OUT_CNT_W-1:0] addr;
        logic [WORDWIDTH-1:0] data;
    } wr_t;

    wr_t sb_q[$];

    pe_result_writer_if bus ();

    pe_result_writer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference result for a finished point
    function automatic logic [31:0] model_out(input logic [31:0] s);
`ifdef RESULT_RELU_EN
        return s[31] ? 32'd0 : s;
`else
        return s;
`endif
    endfunction

    function automatic logic [31:0] beat_val(input int mode, input int p, input int b,
                                             input logic [31:0] base);
        logic [31:0] v;
        if (mode == 0) v = base;
        else           v = base + 32'(p * 7) - 32'(b);
        return v;
    endfunction

    // Offer one beat until accepted; optional random idle cycles (valid low)
    task automatic send_beat(input logic [31:0] d, input bit gap);
        bit sent;
        int n;
        sent = 1'b0;
        n = 0;
        while (!sent && n < 200) begin
            if (gap && ($urandom_range(1, 0) == 0)) begin
                bus.in_valid = 1'b0;
                bus.in_data  = $urandom;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = d;
            end
            sent = bus.in_valid && bus.in_ready;
            @(negedge clk);
            n++;
        end
        bus.in_valid = 1'b0;
        if (!sent) check("beat_timeout", 32'd0, 32'd1);
    endtask

    task automatic start_row();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    // One full row: beats, scoreboarded writes, optional stall / start pokes / abort
    task automatic run_row(input int mode, input logic [31:0] base, input bit gap,
                           input int stall_n, input bit poke, input int abort_after);
        for (int p = 0; p < OUT_PER_ROW; p++) begin
            logic [31:0] sum;
            logic [31:0] v;
            wr_t e;
            wr_t got;
            sum = 32'd0;
            for (int b = 0; b < PSUM_PER_OUT; b++) begin
                v = beat_val(mode, p, b, base);
                if (poke && p == 0 && b == 3) start = 1'b1;
                send_beat(v, gap);
                start = 1'b0;
                sum = sum + v;
            end
            e.addr = OUT_CNT_W'(p);
            e.data = model_out(sum);
            sb_q.push_back(e);

            check("wr_valid_latency", 32'(bus.wr_valid), 32'd1);
            check("in_ready_in_write", 32'(bus.in_ready), 32'd0);
            if (stall_n > 0 && p == 2) begin
                bus.wr_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = 32'h5A5A_0000 + 32'(s);
                    @(negedge clk);
                    check("stall_wr_valid", 32'(bus.wr_valid), 32'd1);
                    check("stall_in_ready", 32'(bus.in_ready), 32'd0);
                    check("stall_wr_addr", 32'(bus.wr_addr), 32'(sb_q[0].addr));
                    check("stall_wr_data", bus.wr_data, sb_q[0].data);
                end
                bus.in_valid = 1'b0;
            end
            got = sb_q.pop_front();
            check("wr_addr", 32'(bus.wr_addr), 32'(got.addr));
            check("wr_data", bus.wr_data, got.data);
            bus.wr_ready = 1'b1;
            @(negedge clk);
            bus.wr_ready = 1'b0;

            if (abort_after == p + 1) begin
                rst_n = 1'b0;
                #1;
                check("abort_in_ready", 32'(bus.in_ready), 32'd0);
                check("abort_wr_valid", 32'(bus.wr_valid), 32'd0);
                check("abort_wr_addr", 32'(bus.wr_addr), 32'd0);
                check("abort_wr_data", bus.wr_data, 32'd0);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                check("abort_sb_empty", 32'(sb_q.size()), 32'd0);
                return;
            end
            if (p != OUT_PER_ROW - 1) check("no_early_done", 32'(done), 32'd0);
        end
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd1);
        if (poke) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_fall", 32'(done), 32'd0);
        check("busy_fall", 32'(busy), 32'd0);
        if (poke) begin
            @(negedge clk);
            check("start_in_done_ignored", 32'(busy), 32'd0);
            check("start_in_done_no_ready", 32'(bus.in_ready), 32'd0);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 32'd0;
        bus.wr_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_wr_valid", 32'(bus.wr_valid), 32'd0);
        check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        check("rst_wr_data", bus.wr_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // all ones: 30 per point
        start_row();
        run_row(0, 32'd1, 1'b0, 0, 1'b0, 0);
        // all -2: -60, or 0 when clamped (back-to-back start)
        start_row();
        run_row(0, 32'hFFFF_FFFE, 1'b0, 0, 1'b0, 0);
        // write stall with beats offered while stalled
        start_row();
        run_row(0, 32'd3, 1'b0, 5, 1'b0, 0);
        // random valid gaps
        start_row();
        run_row(0, 32'd1, 1'b1, 0, 1'b0, 0);
        // start pulsed in ACCUM and in DONE
        start_row();
        run_row(0, 32'd1, 1'b0, 0, 1'b1, 0);
        // reset after 4th write, then a fresh row with per-point distinct sums
        start_row();
        run_row(1, 32'd100, 1'b0, 0, 1'b0, 4);
        start_row();
        run_row(1, 32'd100, 1'b1, 0, 1'b0, 0);
        // wraparound sum of 30 x 0x7FFFFFFF
        start_row();
        run_row(0, 32'h7FFF_FFFF, 1'b0, 0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
